// File: rtl/mov_debounce_pkg.sv
// mov_pkg: shared types and constants for the mov_debounce button block.
//   rpt_state_e       : per-channel auto-repeat state (IDLE, DELAY, REPEAT)
//   DEF_*             : default timing constants in clk50 cycles (50 MHz)
//   CH_*              : channel index of each direction inside the lane arrays
//   cnt_w()           : counter width for a cycle count (never below 1 bit)
package mov_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
  localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD   = 5000000;   // 100 ms

  localparam int NUM_CH   = 4;
  localparam int CH_UP    = 0;
  localparam int CH_DOWN  = 1;
  localparam int CH_LEFT  = 2;
  localparam int CH_RIGHT = 3;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mov_debounce_ch.sv
// mov_debounce_ch: one push-button channel.
//   raw active-low button -> 2-flop synchronizer -> stability counter ->
//   debounced level; a one-cycle pulse in the cycle the level rises.
//   With MOV_AUTOREPEAT_EN defined, a held level also emits repeat pulses
//   after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
// Ports:
//   clk50   : system clock (rising edge)
//   rst_n   : asynchronous active-low reset
//   i_btn_n : raw button, active-low, asynchronous
//   o_lvl   : debounced level, active-high
//   o_pls   : single-cycle press / repeat pulse
module mov_debounce_ch
  import mov_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_lvl,
  output logic o_pls
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("mov_debounce_ch: timing parameters must be >= 1");
  end

  localparam int             DW      = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1, r_sync2;
  logic [DW-1:0] r_cnt;
  logic          r_lvl, r_pls;
  logic          w_act, w_flip, w_rise, w_fire;

  // Synchronizer resets to "released" so a button held through reset is
  // seen as a fresh press once reset lifts.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_act  = ~r_sync2;
  // Level flips on the cycle the DEBOUNCE_CYCLES-th consecutive mismatch is seen.
  assign w_flip = (w_act != r_lvl) && (r_cnt >= DB_LAST);
  assign w_rise = w_flip & ~r_lvl;

  // Counter stops at DB_LAST (the flip clears it), so it never wraps.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_lvl <= 1'b0;
    end else if (w_act == r_lvl || w_flip) begin
      r_cnt <= '0;
      r_lvl <= r_lvl ^ w_flip;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef MOV_AUTOREPEAT_EN
  localparam int            TW      = cnt_w((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                           : REPEAT_PERIOD);
  localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);

  rpt_state_e    r_state, w_state_nxt;
  logic [TW-1:0] r_tmr, w_tmr_nxt;
  logic          w_fall;

  assign w_fall = w_flip & r_lvl;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  // Falling level wins over everything: the machine is IDLE in the same
  // cycle the level reads 0, so a pulse due then is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    if (w_fall) begin
      w_state_nxt = IDLE;
      w_tmr_nxt   = '0;
    end else if (w_rise) begin
      w_state_nxt = DELAY;
      w_tmr_nxt   = '0;
    end else begin
      unique case (r_state)
        DELAY: begin
          if (r_tmr >= RD_LAST) begin
            w_state_nxt = REPEAT;
            w_tmr_nxt   = '0;
          end else begin
            w_tmr_nxt = r_tmr + 1'b1;
          end
        end
        REPEAT: begin
          if (r_tmr >= RP_LAST) w_tmr_nxt = '0;
          else                  w_tmr_nxt = r_tmr + 1'b1;
        end
        default: begin
          w_state_nxt = IDLE;
          w_tmr_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_fire = 1'b0;
    if (!w_fall && !w_rise) begin
      unique case (r_state)
        DELAY:   w_fire = (r_tmr >= RD_LAST);
        REPEAT:  w_fire = (r_tmr >= RP_LAST);
        default: w_fire = 1'b0;
      endcase
    end
  end
`else
  assign w_fire = 1'b0;
`endif

  // Registered so the pulse lines up with the cycle the level rises.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) r_pls <= 1'b0;
    else        r_pls <= w_rise | w_fire;
  end

  assign o_lvl = r_lvl;
  assign o_pls = r_pls;

endmodule

// File: rtl/mov_debounce.sv
// mov_debounce: four-direction push-button debouncer.
//   Four mov_debounce_ch lanes plus opposite-direction pulse suppression:
//   simultaneous up+down (or left+right) pulses cancel each other; levels
//   are never suppressed.
//   Optional feature: define MOV_AUTOREPEAT_EN for held-button auto-repeat.
// Ports:
//   clk50, rst_n                       : 50 MHz clock, async active-low reset
//   movUp/movDown/movLeft/movRight     : raw active-low buttons
//   upLvl/downLvl/leftLvl/rightLvl     : debounced active-high levels
//   upPls/downPls/leftPls/rightPls     : single-cycle move pulses
module mov_debounce
  import mov_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic movUp,
  input  logic movDown,
  input  logic movLeft,
  input  logic movRight,
  output logic upLvl,
  output logic downLvl,
  output logic leftLvl,
  output logic rightLvl,
  output logic upPls,
  output logic downPls,
  output logic leftPls,
  output logic rightPls
);

  logic [NUM_CH-1:0] w_btn_n, w_lvl, w_pls;

  assign w_btn_n = {movRight, movLeft, movDown, movUp};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mov_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk50  (clk50),
      .rst_n  (rst_n),
      .i_btn_n(w_btn_n[g]),
      .o_lvl  (w_lvl[g]),
      .o_pls  (w_pls[g])
    );
  end

  assign upLvl    = w_lvl[CH_UP];
  assign downLvl  = w_lvl[CH_DOWN];
  assign leftLvl  = w_lvl[CH_LEFT];
  assign rightLvl = w_lvl[CH_RIGHT];

  assign upPls    = w_pls[CH_UP]    & ~w_pls[CH_DOWN];
  assign downPls  = w_pls[CH_DOWN]  & ~w_pls[CH_UP];
  assign leftPls  = w_pls[CH_LEFT]  & ~w_pls[CH_RIGHT];
  assign rightPls = w_pls[CH_RIGHT] & ~w_pls[CH_LEFT];

endmodule
